// File: rtl/score_display.sv
// Saturating multi-digit BCD score counter with a registered, active-low
// seven-segment driver that supports leading-zero blanking and whole-display blinking.

module score_digit_dec (
    input  logic [3:0] val,
    input  logic       blank,
    output logic [6:0] seg
);
    // Active-low segments, bit order {g,f,e,d,c,b,a}
    always_comb begin
        seg = 7'b1111111;
        if (!blank) begin
            case (val)
                4'd0:    seg = 7'b1000000;
                4'd1:    seg = 7'b1111001;
                4'd2:    seg = 7'b0100100;
                4'd3:    seg = 7'b0110000;
                4'd4:    seg = 7'b0011001;
                4'd5:    seg = 7'b0010010;
                4'd6:    seg = 7'b0000010;
                4'd7:    seg = 7'b1111000;
                4'd8:    seg = 7'b0000000;
                4'd9:    seg = 7'b0011000;
                default: seg = 7'b1111111;
            endcase
        end
    end
endmodule

module score_display #(
    parameter int DIGITS        = 4,
    parameter int BLINK_DIV     = 25000000,
    parameter int LEADING_BLANK = 1
) (
    input  logic                  CLOCK_50,
    input  logic                  resetn,
    input  logic                  inc,
    input  logic                  clr,
    input  logic                  blink_en,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [7*DIGITS-1:0]   segs,
    output logic                  sat
);
    localparam int CW = $clog2(BLINK_DIV);
    localparam logic [CW-1:0] CNT_MAX = CW'(BLINK_DIV - 1);

    logic [DIGITS-1:0][3:0] score, score_inc, score_nxt;
    logic [DIGITS-1:0][6:0] seg_nxt, seg_q;
    logic [DIGITS-1:0]      blank_lead;
    logic [CW-1:0]          cnt;
    logic                   phase;
    logic                   carry;
    logic                   zero_run;

    // Decimal ripple increment across all nibbles in one cycle
    always_comb begin
        score_inc = score;
        carry     = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            if (carry) begin
                if (score[k] == 4'd9) begin
                    score_inc[k] = 4'd0;
                end else begin
                    score_inc[k] = score[k] + 4'd1;
                    carry        = 1'b0;
                end
            end
        end
    end

    always_comb begin
        score_nxt = score;
        if (clr)
            score_nxt = '0;
        else if (inc && !sat)
            score_nxt = score_inc;
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            score <= '0;
            sat   <= 1'b0;
        end else begin
            score <= score_nxt;
            sat   <= (score_nxt == {DIGITS{4'd9}});
        end
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            cnt   <= '0;
            phase <= 1'b0;
        end else if (clr || !blink_en) begin
            cnt   <= '0;
            phase <= 1'b0;
        end else if (cnt == CNT_MAX) begin
            cnt   <= '0;
            phase <= ~phase;
        end else begin
            cnt   <= cnt + CW'(1);
        end
    end

    // Scan from the most significant digit down; digit 0 is always shown
    always_comb begin
        zero_run   = 1'b1;
        blank_lead = '0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            zero_run      = zero_run && (score[k] == 4'd0);
            blank_lead[k] = (LEADING_BLANK != 0) && (k > 0) && zero_run;
        end
    end

    for (genvar g = 0; g < DIGITS; g++) begin : g_dig
        score_digit_dec u_dec (
            .val   (score[g]),
            .blank (blank_lead[g] | phase),
            .seg   (seg_nxt[g])
        );
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            for (int k = 0; k < DIGITS; k++)
                seg_q[k] <= ((k > 0) && (LEADING_BLANK != 0)) ? 7'b1111111 : 7'b1000000;
        end else begin
            seg_q <= seg_nxt;
        end
    end

    assign bcd  = score;
    assign segs = seg_q;
endmodule

// File: tb/tb_score_display.sv
// Directed bench: a 4-digit and a 2-digit instance share stimulus (BLINK_DIV=4).

module tb_score_display;
    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] S7 = 7'b1111000;
    localparam logic [6:0] S9 = 7'b0011000;
    localparam logic [6:0] BL = 7'b1111111;

    logic clk = 1'b0, rst_n = 1'b0, inc = 1'b0, clr = 1'b0, blink_en = 1'b0;
    logic [15:0] bcd4;
    logic [27:0] segs4;
    logic        sat4;
    logic [7:0]  bcd2;
    logic [13:0] segs2;
    logic        sat2;
    int pass_cnt = 0;
    int total    = 0;

    always #5 clk = ~clk;

    score_display #(.DIGITS(4), .BLINK_DIV(4), .LEADING_BLANK(1)) dut (
        .CLOCK_50(clk), .resetn(rst_n), .inc(inc), .clr(clr), .blink_en(blink_en),
        .bcd(bcd4), .segs(segs4), .sat(sat4));

    score_display #(.DIGITS(2), .BLINK_DIV(4), .LEADING_BLANK(1)) dut2 (
        .CLOCK_50(clk), .resetn(rst_n), .inc(inc), .clr(clr), .blink_en(blink_en),
        .bcd(bcd2), .segs(segs2), .sat(sat2));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] to_bcd2(int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    task automatic test_reset();
        #12;
        total++;
        if (bcd4 !== 16'h0000 || sat4 !== 1'b0) $display("FAIL reset_bcd4 got %h/%b want 0000/0", bcd4, sat4);
        else pass_cnt++;
        total++;
        if (segs4 !== {BL, BL, BL, S0}) $display("FAIL reset_segs4 got %h want %h", segs4, {BL, BL, BL, S0});
        else pass_cnt++;
        total++;
        if (segs2 !== {BL, S0} || bcd2 !== 8'h00 || sat2 !== 1'b0)
            $display("FAIL reset_dut2 got %h/%h/%b want %h/00/0", segs2, bcd2, sat2, {BL, S0});
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            total++;
            if (bcd4 !== 16'h0000 || sat4 !== 1'b0 || segs4 !== {BL, BL, BL, S0})
                $display("FAIL reset_hold cyc %0d got %h/%b/%h", i, bcd4, sat4, segs4);
            else pass_cnt++;
        end
    endtask

    task automatic test_ripple();
        for (int i = 0; i < 199; i++) begin
            inc = 1'b1; step();
            inc = 1'b0; step();
        end
        total++;
        if (bcd4 !== 16'h0199) $display("FAIL ripple_bcd got %h want 0199", bcd4);
        else pass_cnt++;
        step();
        total++;
        if (segs4 !== {BL, S1, S9, S9}) $display("FAIL ripple_segs got %h want %h", segs4, {BL, S1, S9, S9});
        else pass_cnt++;
        total++;
        if (bcd2 !== 8'h99 || sat2 !== 1'b1) $display("FAIL sat2_after_199 got %h/%b want 99/1", bcd2, sat2);
        else pass_cnt++;
        inc = 1'b1; step(); inc = 1'b0;
        total++;
        if (bcd4 !== 16'h0200 || sat4 !== 1'b0) $display("FAIL ripple_carry got %h/%b want 0200/0", bcd4, sat4);
        else pass_cnt++;
        step();
        total++;
        if (segs4 !== {BL, S2, S0, S0}) $display("FAIL ripple_segs200 got %h want %h", segs4, {BL, S2, S0, S0});
        else pass_cnt++;
    endtask

    task automatic test_saturation();
        clr = 1'b1; step(); clr = 1'b0;
        inc = 1'b1;
        for (int i = 1; i <= 105; i++) begin
            step();
            total++;
            if (bcd2 !== to_bcd2(i > 99 ? 99 : i) || sat2 !== (i >= 99))
                $display("FAIL sat_run edge %0d got %h/%b want %h/%b", i, bcd2, sat2,
                         to_bcd2(i > 99 ? 99 : i), (i >= 99));
            else pass_cnt++;
        end
        inc = 1'b0;
        total++;
        if (bcd4 !== 16'h0105) $display("FAIL sat_dut4 got %h want 0105", bcd4);
        else pass_cnt++;
    endtask

    task automatic test_clear_priority();
        clr = 1'b1; inc = 1'b1; step(); clr = 1'b0; inc = 1'b0;
        total++;
        if (bcd2 !== 8'h00 || sat2 !== 1'b0) $display("FAIL clr_from_sat got %h/%b want 00/0", bcd2, sat2);
        else pass_cnt++;
        inc = 1'b1;
        repeat (57) step();
        inc = 1'b0;
        total++;
        if (bcd4 !== 16'h0057 || bcd2 !== 8'h57) $display("FAIL count57 got %h/%h want 0057/57", bcd4, bcd2);
        else pass_cnt++;
        clr = 1'b1; inc = 1'b1; step(); clr = 1'b0; inc = 1'b0;
        total++;
        if (bcd4 !== 16'h0000 || bcd2 !== 8'h00 || sat2 !== 1'b0)
            $display("FAIL clr_prio got %h/%h/%b want 0000/00/0", bcd4, bcd2, sat2);
        else pass_cnt++;
        total++;
        if (segs2 !== {S5, S7}) $display("FAIL clr_seg_lag got %h want %h", segs2, {S5, S7});
        else pass_cnt++;
        step();
        total++;
        if (segs2 !== {BL, S0} || segs4 !== {BL, BL, BL, S0})
            $display("FAIL clr_segs got %h/%h want %h/%h", segs2, segs4, {BL, S0}, {BL, BL, BL, S0});
        else pass_cnt++;
    endtask

    task automatic test_blink();
        logic [27:0] exp4;
        inc = 1'b1; repeat (3) step(); inc = 1'b0;
        step();
        total++;
        if (segs4 !== {BL, BL, BL, S3}) $display("FAIL blink_pre got %h want %h", segs4, {BL, BL, BL, S3});
        else pass_cnt++;
        blink_en = 1'b1;
        for (int k = 1; k <= 13; k++) begin
            step();
            exp4 = (((k - 1) / 4) % 2 == 1) ? {4{BL}} : {BL, BL, BL, S3};
            total++;
            if (segs4 !== exp4) $display("FAIL blink edge %0d got %h want %h", k, segs4, exp4);
            else pass_cnt++;
        end
        blink_en = 1'b0;
        step();
        total++;
        if (segs4 !== {4{BL}}) $display("FAIL blink_drop_lag got %h want %h", segs4, {4{BL}});
        else pass_cnt++;
        step();
        total++;
        if (segs4 !== {BL, BL, BL, S3} || segs2 !== {BL, S3})
            $display("FAIL blink_drop got %h/%h want %h/%h", segs4, segs2, {BL, BL, BL, S3}, {BL, S3});
        else pass_cnt++;
    endtask

    task automatic test_async_reset();
        logic [27:0] exp4;
        blink_en = 1'b1;
        repeat (5) step();
        total++;
        if (segs4 !== {4{BL}}) $display("FAIL ar_blank got %h want %h", segs4, {4{BL}});
        else pass_cnt++;
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (bcd4 !== 16'h0000 || sat4 !== 1'b0 || segs4 !== {BL, BL, BL, S0} || segs2 !== {BL, S0})
            $display("FAIL async_reset got %h/%b/%h/%h", bcd4, sat4, segs4, segs2);
        else pass_cnt++;
        blink_en = 1'b0;
        #2 rst_n = 1'b1;
        step();
        blink_en = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            exp4 = (((k - 1) / 4) % 2 == 1) ? {4{BL}} : {BL, BL, BL, S0};
            total++;
            if (segs4 !== exp4) $display("FAIL ar_blink edge %0d got %h want %h", k, segs4, exp4);
            else pass_cnt++;
        end
        blink_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_ripple();
        test_saturation();
        test_clear_priority();
        test_blink();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule

// File: doc/score_display.md
# score_display

Parametrised multi-digit decimal score counter with a registered seven-segment driver for the board HEX displays. It replaces per-digit hex decoding of raw values: it keeps a saturating BCD score, blanks leading zeros, and can blink the whole display. The game FSM drives it from the 50 MHz domain, and its segment bus connects directly to HEX0..HEX(DIGITS-1).

## Interface
- DIGITS, 4: number of decimal digits, 1..8; digit 0 is least significant.
- BLINK_DIV, 25000000: clock cycles per blink half-period; must be ≥ 2.
- LEADING_BLANK, 1: 1 blanks leading zeros; 0 shows every digit.
- CLOCK_50  in  1  system clock; all logic is on its rising edge.
- resetn  in  1  asynchronous, active-low reset.
- inc  in  1  add 1 to score on each cycle it is high.
- clr  in  1  synchronous clear of score to 0.
- blink_en  in  1  high enables blinking of all digits.
- bcd  out  4*DIGITS  current score; digit k is at [4k+3:4k].
- segs  out  7*DIGITS  active-low segments; digit k is at [7k+6:7k], bit order {g,f,e,d,c,b,a}.
- sat  out  1  high while score equals all nines.

## Operation
- Score register: DIGITS BCD nibbles, each always in the range 0..9.
- Priority per cycle: clr, then inc.
  - clr sets the score to 0, clears sat, and restarts the blink phase.
  - inc with sat=0 adds 1 with decimal ripple carry in the same cycle. Example: 0199 becomes 0200.
  - inc with sat=1 is ignored. The score holds and there is no wrap.
- sat is registered and equals (next score == all 9s). It rises on the same edge that loads 99..9.
- Digit encoding for values 0..9:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001.
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0011000.
  - Blank is 1111111.
- Leading blank (LEADING_BLANK=1): digit k is blank if every digit ≥ k is 0 and k > 0. Digit 0 is never blanked by this rule.
- Blink:
  - The counter counts 0..BLINK_DIV-1 while blink_en=1, and a phase bit toggles on wrap.
  - Phase 0 means digits are shown; phase 1 means all digits are blank.
  - While blink_en=0, the counter and phase are held at 0 and the display is always on.
  - A rising edge of blink_en starts in phase 0.
- segs is a register. It is computed from the score and blink phase registered on the previous edge.

## Timing
- Reset values:
  - bcd = 0 and sat = 0.
  - Blink counter = 0 and phase = 0.
  - segs: digit 0 = 1000000. The other digits are 1111111 if LEADING_BLANK=1, else 1000000.
- inc or clr sampled at edge n: bcd and sat change at edge n. segs reflects the change at edge n+1 (one-cycle latency).
- Holding inc high for N cycles adds N, subject to saturation. The block does no edge detection.
- Blink: with blink_en high from edge 0, the phase toggles at edges BLINK_DIV, 2·BLINK_DIV, and so on. segs follows one cycle later.
- blink_en falling: the phase returns to 0 at that edge, and segs shows digits on the next edge.
- resetn asserted mid-count: all registers take their reset values immediately, independent of the clock. Release is synchronous to the next edge.
- Width rule: the blink counter is $clog2(BLINK_DIV) bits wide. It produces no carry beyond BLINK_DIV-1.

## Test plan
- Reset check (DIGITS=4, LEADING_BLANK=1): assert resetn=0 → bcd=0000, sat=0, segs digit0=1000000, digits 1..3=1111111. Release and check that nothing changes over 10 cycles.
- Ripple and blanking: pulse inc 199 times → bcd=0199. One cycle later segs = {blank, 1111001, 0011000, 0011000}. One more inc → bcd=0200, and digit 1 shows 1000000.
- Saturation (DIGITS=2): from 00, hold inc for 105 cycles → bcd=99 and sat=1 from the 99th edge onward. bcd stays at 99, with no wrap to 00.
- Clear priority: at score 57, assert clr and inc together for one cycle → bcd=00 and sat=0. segs digit0=1000000 and digit1 is blank one cycle later.
- Blink (BLINK_DIV=4): score 3 with blink_en high → segs alternates between digit0=0110000 and all blank every 4 cycles, with a 1-cycle lag. Drop blink_en in the blank phase → digits are shown on the following edge.
- Async reset mid-blink: assert resetn low between edges while in the blank phase → bcd=0 and segs at reset values with no clock edge. Release, then raise blink_en → starts in phase 0.
